addsub_multicycle: RTL and testbench

Parametrised, multi-cycle add/subtract unit that computes A+B or A−B over WIDTH bits, CHUNK bits per clock, using a single CHUNK-bit adder with two's-complement subtraction (invert B, carry-in 1). It is the next generation of the team's fixed 4-bit subtractor: it adds run-time mode select, valid/ready handshakes on input and output, and carry/overflow/zero/negative flags. It sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/addsub_multicycle_if.sv | 28 ++
 rtl/addsub_multicycle.sv | 99 +++++++++
 tb/tb_addsub_multicycle.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_multicycle_if.sv
// Handshake and data bundle for addsub_multicycle: operand issue side plus
// result/flag consumer side.
interface addsub_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_multicycle.sv
// Multi-cycle add/subtract: one CHUNK-bit adder walks WIDTH/CHUNK chunks LSB first.
// Optional signed saturation on overflow when macro SAT_EN is defined.
module addsub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                clk,
    input logic                rst,
    addsub_multicycle_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   csum;
    logic             raw_ovf;

    // b_q already holds ~b for subtraction, so the adder never sees the mode.
    always_comb begin
        csum = {1'b0, a_q[int'(cnt)*CHUNK +: CHUNK]}
             + {1'b0, b_q[int'(cnt)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
        raw = acc;
        raw[int'(cnt)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        raw_ovf = (a_q[MSB] == b_q[MSB]) && (raw[MSB] != a_q[MSB]);
`ifdef SAT_EN
        if (raw_ovf)
            fin = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            fin = raw;
`else
        fin = raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
            bus.neg       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc           <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.a;
                        b_q          <= bus.sub ? ~bus.b : bus.b;
                        carry        <= bus.sub;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= raw;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    // Flags and the visible result update only once, on the last chunk.
                    if (cnt == CW'(NCH - 1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= fin;
                        bus.cout      <= csum[CHUNK];
                        bus.ovf       <= raw_ovf;
                        bus.zero      <= (fin == '0);
                        bus.neg       <= fin[MSB];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed-vector bench for addsub_multicycle (WIDTH=16, CHUNK=4) with stall and reset sequences.
module tb_addsub_multicycle;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_multicycle_if #(.WIDTH(WIDTH)) bus ();
    addsub_multicycle #(.WIDTH(WIDTH), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic start_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                            input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy_before"}, {31'd0, bus.in_ready}, 32'd1);
        bus.sub      = s;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.sub      = 1'($urandom);
        chk({tag, "_rdy_after"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, "_res"},  {16'd0, bus.result}, {16'd0, v.res});
        chk({tag, "_cout"}, {31'd0, bus.cout},   {31'd0, v.c});
        chk({tag, "_ovf"},  {31'd0, bus.ovf},    {31'd0, v.o});
        chk({tag, "_zero"}, {31'd0, bus.zero},   {31'd0, v.z});
        chk({tag, "_neg"},  {31'd0, bus.neg},    {31'd0, v.n});
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic do_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.sub, v.a, v.b, tag);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        check_out(v, tag);
        release_out(tag);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ov"},   {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_rdy"},  {31'd0, bus.in_ready},  32'd1);
        chk({tag, "_res"},  {16'd0, bus.result},    32'd0);
        chk({tag, "_flags"}, {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   lat;
        int   seen;

        //            sub a         b         res       c  o  z  n
        vecs[0]  = '{1'b1, 16'h0006, 16'h0003, 16'h0003, 1, 0, 0, 0};
        vecs[1]  = '{1'b1, 16'h0004, 16'h0005, 16'hFFFF, 0, 0, 0, 1};
        vecs[2]  = '{1'b1, 16'h000F, 16'h000F, 16'h0000, 1, 0, 1, 0};
`ifdef SAT_EN
        vecs[3]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 1, 0, 0};
        vecs[4]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 1, 1, 0, 1};
        vecs[8]  = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 1, 1, 0, 1};
`else
        vecs[3]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1};
        vecs[4]  = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0};
        vecs[8]  = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 0};
`endif
        vecs[5]  = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0};
        vecs[6]  = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0};
        vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0};
        vecs[9]  = '{1'b1, 16'h1000, 16'h0FFF, 16'h0001, 1, 0, 0, 0};
        vecs[10] = '{1'b0, 16'h0FFF, 16'h0001, 16'h1000, 0, 0, 0, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outs("reset");

        for (int i = 0; i < 11; i++)
            do_vec(vecs[i], $sformatf("v%0d", i));

        // Stall in DONE while a new request waits; it must not be taken early.
        v = '{1'b0, 16'h0100, 16'h0023, 16'h0123, 0, 0, 0, 0};
        start_op(v.sub, v.a, v.b, "stall");
        wait_done(lat);
        chk("stall_lat", 32'(lat), 32'd4);
        bus.in_valid = 1'b1;
        bus.sub      = 1'b1;
        bus.a        = 16'h0050;
        bus.b        = 16'h0010;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d_ov", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("stall_hold%0d_rdy", k), {31'd0, bus.in_ready}, 32'd0);
            check_out(v, $sformatf("stall_hold%0d", k));
        end
        release_out("stall");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("stall_next_taken", {31'd0, bus.in_ready}, 32'd0);
        wait_done(lat);
        chk("stall_next_lat", 32'(lat), 32'd4);
        check_out('{1'b1, 16'h0050, 16'h0010, 16'h0040, 1, 0, 0, 0}, "stall_next");
        release_out("stall_next");

        // Reset during the second BUSY cycle discards the operation.
        start_op(1'b0, 16'hFFFF, 16'h0001, "rbusy");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outs("rbusy");
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("rbusy_no_result", 32'(seen), 32'd0);
        do_vec('{1'b0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0}, "after_rbusy");

        // Reset while holding a result in DONE.
        start_op(1'b1, 16'h0004, 16'h0005, "rdone");
        wait_done(lat);
        chk("rdone_ov", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outs("rdone");
        do_vec(vecs[0], "after_rdone");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
